// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// pg_t is one prefix node: group generate and group propagate.
package ksa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pipeline latency: one operand stage plus one stage per prefix level.
  function automatic int lat_of(input int width);
    return clog2(width) + 1;
  endfunction

endpackage

// File: rtl/ksa_pipe_adder_prefix.sv
// One combinational Kogge-Stone prefix level (module ksa_prefix_level).
// Node index 0 holds the carry-in (prefix position -1); index i+1 holds bit i.
// Nodes closer than SPAN to the bottom have already resolved and pass through.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  pg_t [WIDTH:0] grp_i,
  output pg_t [WIDTH:0] grp_o
);

  // Combine each node with the node SPAN positions below it.
  always_comb begin
    // NOTE: assigning a full default first guarantees every bit is written on
    // every path, so no latch can be inferred for the pass-through nodes.
    grp_o = grp_i;
    for (int i = SPAN; i <= WIDTH; i++) begin
      grp_o[i].g = grp_i[i].g | (grp_i[i].p & grp_i[i-SPAN].g);
      grp_o[i].p = grp_i[i].p & grp_i[i-SPAN].p;
    end
  end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder with valid/ready handshake and synchronous flush.
// Stage 0 registers bitwise p/g and the carry-in; stage k registers prefix
// level k (span 2^(k-1)). Sum, carry-out and overflow are formed from the last
// stage. Optional build macro KSA_PIPE_SUB_EN adds an in_sub port for a - b.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef KSA_PIPE_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int LAT    = lat_of(WIDTH);

  logic [LAT-1:0]   valid_q, valid_d;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  pg_t  [WIDTH:0]   grp0_d;
  pg_t  [WIDTH:0]   lvl_d [1:LEVELS];
  pg_t  [WIDTH:0]   grp_q [LAT];
  logic [WIDTH-1:0] p_d   [LAT];
  logic [WIDTH-1:0] p_q   [LAT];
  logic [WIDTH-1:0] carry;

  // Operand conditioning: subtraction is a + ~b + 1.
  always_comb begin
`ifdef KSA_PIPE_SUB_EN
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub ? 1'b1  : in_cin;
`else
    b_eff   = in_b;
    cin_eff = in_cin;
`endif
  end

  // Stage-0 node vector with the carry-in folded in as a pure generate node,
  // plus the bitwise propagate vector that travels alongside for the sum.
  always_comb begin
    grp0_d[0] = '{g: cin_eff, p: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      grp0_d[i+1] = '{g: in_a[i] & b_eff[i], p: in_a[i] ^ b_eff[i]};
    end
    p_d[0] = in_a ^ b_eff;
    for (int k = 1; k < LAT; k++) begin
      p_d[k] = p_q[k-1];
    end
  end

  // Prefix levels, each fed from the previous stage register.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ksa_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << (k - 1))
    ) u_level (
      .grp_i (grp_q[k-1]),
      .grp_o (lvl_d[k])
    );
  end

  // Handshake: the whole pipe moves together; flush wins over advance.
  always_comb begin
    advance  = !valid_q[LAT-1] | out_ready;
    in_ready = advance & !flush;
    valid_d  = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d = {valid_q[LAT-2:0], in_valid & in_ready};
    end
  end

  // Valid bits: the only state that needs reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data stages shift with the valid bits and hold while stalled.
  // NOTE: datapath registers are deliberately not reset; their content is
  // meaningless while the matching valid bit is 0.
  always_ff @(posedge clk) begin
    if (advance) begin
      grp_q[0] <= grp0_d;
      for (int k = 1; k < LAT; k++) begin
        grp_q[k] <= lvl_d[k];
      end
      for (int k = 0; k < LAT; k++) begin
        p_q[k] <= p_d[k];
      end
    end
  end

  // Result: node i of the last stage is the carry into bit i. The top node
  // spans bits 0..WIDTH-1 only, so it is closed with the carry-in node.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = grp_q[LAT-1][i].g;
    end
    out_sum   = p_q[LAT-1] ^ carry;
    out_cout  = grp_q[LAT-1][WIDTH].g |
                (grp_q[LAT-1][WIDTH].p & grp_q[LAT-1][0].g);
    out_ovf   = carry[WIDTH-1] ^ out_cout;
    out_valid = valid_q[LAT-1];
  end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Scoreboard bench for ksa_pipe_adder (WIDTH=8, latency 4). Accepted operand
// sets push a model result; a negedge monitor pops on every output transfer.
// Build with KSA_PIPE_SUB_EN defined to include the subtract cases.
module tb_ksa_pipe_adder;

  localparam int WIDTH = 8;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
`ifdef KSA_PIPE_SUB_EN
  logic             in_sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  ksa_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef KSA_PIPE_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH+1:0] res;   // {ovf, cout, sum}
    int               cyc;
    bit               timed;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;
  bit               timed_mode = 1'b1;
  bit               rand_ready = 1'b0;
  bit               cur_sub = 1'b0;
  bit               held_vld = 1'b0;
  logic [WIDTH+1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; overflow from operand/result signs.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input bit sub);
    logic [WIDTH-1:0] bo;
    logic [WIDTH:0]   full;
    logic             ovf;
    bo   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bo} + (sub ? 1 : {{WIDTH{1'b0}}, cin});
    ovf  = (a[WIDTH-1] == bo[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ovf, full};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      held_vld = 1'b0;
      check("out_valid_in_reset", {63'd0, out_valid}, 64'd0);
    end else begin
      if (held_vld && out_valid)
        check("stall_hold", {54'd0, out_ovf, out_cout, out_sum}, {54'd0, held});
      held_vld = 1'b0;
      if (flush) begin
        sb.delete();
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum 0x%0h, expected no output (cycle %0d)", out_sum, cyc);
        end else begin
          e = sb.pop_front();
          check("result", {54'd0, out_ovf, out_cout, out_sum}, {54'd0, e.res});
          if (e.timed) check("latency", 64'(cyc - e.cyc), 64'(LAT));
        end
      end else if (out_valid) begin
        held     = {out_ovf, out_cout, out_sum};
        held_vld = 1'b1;
      end
      if (in_valid && in_ready) begin
        e.res   = model(in_a, in_b, in_cin, cur_sub);
        e.cyc   = cyc;
        e.timed = timed_mode;
        sb.push_back(e);
      end
    end
  end

  // Random sink back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Offer one operand set from posedge+1; return at posedge+1 after acceptance.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input bit sub);
    bit accepted;
    accepted = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    cur_sub  = sub;
`ifdef KSA_PIPE_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    check("out_valid_after_reset", {63'd0, out_valid}, 64'd0);
    idle(1);

    // Directed boundary sums with timed latency.
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    idle(6);
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'h80, 8'h80, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'h00, 8'h00, 1'b1, 1'b0);
`ifdef KSA_PIPE_SUB_EN
    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b1, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1);
`endif
    idle(6);

    // Sixteen back-to-back transfers: each result exactly LAT cycles later.
    for (int i = 0; i < 16; i++)
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    idle(8);

    // Fill the pipe with the sink stalled, hold 5 cycles, then drain.
    timed_mode = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < LAT; i++)
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(8);
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Random operands under random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
`ifdef KSA_PIPE_SUB_EN
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`else
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
`endif
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(10);
    check("random_drained", 64'(sb.size()), 64'd0);
    timed_mode = 1'b1;

    // Reset with three operations in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++)
      send(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("out_valid_async_reset", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_midreset", {63'd0, in_ready}, 64'd1);
    check("out_valid_after_midreset", {63'd0, out_valid}, 64'd0);
    idle(8);

    // Flush with three operations in flight.
    for (int i = 0; i < 3; i++)
      send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    idle(8);

    // Pipe still works after flush.
    send(8'h12, 8'h34, 1'b1, 1'b0);
    idle(8);
    check("final_queue_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
